// File: rtl/ffd_en_pipe_pkg.sv
// ffd_en_pipe_pkg: shared energy-detection constants and helpers
package ffd_en_pipe_pkg;

    localparam int DEF_WIDTH = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/ffd_en_vec.sv
// ffd_en_vec: one W-bit enabled register stage with sync reset and flush
module ffd_en_vec #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // reset and flush both clear the stage; otherwise load only when enabled
    always_ff @(posedge clk) begin
        if (rst || clr) q <= '0;
        else if (en)    q <= d;
    end

endmodule

// File: rtl/ffd_en_pipe.sv
// ffd_en_pipe: enabled WIDTH x DEPTH delay line with valid tracking, tap and occupancy
module ffd_en_pipe
    import ffd_en_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = 4,
    localparam int CNT_W = clog2(DEPTH + 1),
    localparam int TAP_W = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    input  logic [TAP_W-1:0] tap_sel,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [WIDTH-1:0] tap_q,
    output logic             tap_valid,
    output logic [CNT_W-1:0] fill_cnt,
    output logic             primed
);

    // each stage word is {valid, data}
    logic [WIDTH:0] st [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic [WIDTH:0] din;
        if (g == 0) begin : g_head
            assign din = {d_valid, d};
        end else begin : g_body
            assign din = st[g-1];
        end
        ffd_en_vec #(.W(WIDTH + 1)) u_stage (
            .clk (clk),
            .rst (rst),
            .clr (clr),
            .en  (en),
            .d   (din),
            .q   (st[g])
        );
    end

    assign {q_valid, q} = st[DEPTH-1];
    assign primed       = fill_cnt == CNT_W'(DEPTH);

    // occupancy tracks valids entering at the head minus the one leaving the tail
    always_ff @(posedge clk) begin
        if (rst || clr) fill_cnt <= '0;
        else if (en)    fill_cnt <= fill_cnt + CNT_W'(d_valid) - CNT_W'(q_valid);
    end

    // tap mux; an index past the last stage selects nothing and yields zeros
    always_comb begin
        {tap_valid, tap_q} = '0;
        for (int i = 0; i < DEPTH; i++)
            if (DEPTH == 1 || TAP_W'(i) == tap_sel) {tap_valid, tap_q} = st[i];
    end

endmodule

// File: doc/ffd_en_pipe.md
Name: ffd_en_pipe

Overview:
Parametrised enabled register pipeline, generalising the single-bit enabled flip-flop to a WIDTH-bit, DEPTH-stage delay line with per-stage valid tracking. Adds synchronous flush, a runtime-selectable tap, and an occupancy counter that reports when the line holds DEPTH valid samples. Used in the energy-detection datapath to align sample streams with delayed threshold and decision signals, and to gate decisions until the window is primed.

Parameters:
WIDTH, 16, data bits per sample (>=1)
DEPTH, 4, number of pipeline stages (>=1)
CNT_W, clog2(DEPTH+1), width of occupancy counter (derived, localparam)
TAP_W, max(1,clog2(DEPTH)), width of tap select (derived, localparam)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
clr  in  1  synchronous flush of data, valids and counter
en  in  1  shift enable; pipeline holds when low
d  in  WIDTH  input sample
d_valid  in  1  qualifies d, sampled only when en=1
tap_sel  in  TAP_W  stage index for tap output (0 = first stage)
q  out  WIDTH  last stage data, stage[DEPTH-1]
q_valid  out  1  valid bit of last stage
tap_q  out  WIDTH  data of stage[tap_sel]
tap_valid  out  1  valid bit of stage[tap_sel]
fill_cnt  out  CNT_W  number of valid stages, 0..DEPTH
primed  out  1  high when fill_cnt == DEPTH

Behaviour:
- Priority per rising edge: rst > clr > en > hold.
- rst=1: all stage data 0, all valid bits 0, fill_cnt 0. So q=0, q_valid=0, tap_q=0, tap_valid=0, primed=0 from the cycle after rst is sampled. rst needs no en.
- clr=1 (rst=0): same effect as rst, regardless of en, d_valid.
- en=1: stage[0] <= d, valid[0] <= d_valid; stage[k] <= stage[k-1], valid[k] <= valid[k-1] for k=1..DEPTH-1. Invalid samples still shift; data is not zeroed when d_valid=0.
- en=0: all stages, valids, fill_cnt hold.
- Latency: a sample presented with en=1 on edge n appears on q after DEPTH enabled edges; with en tied high, edge n+DEPTH-1 drives it (q visible in cycle n+DEPTH-1 .. n+DEPTH).
- fill_cnt on shift: fill_cnt + d_valid - valid[DEPTH-1]; net 0 when both 1. Never exceeds DEPTH or drops below 0 by construction; must equal popcount(valid[]) at all times.
- primed: combinational compare fill_cnt == DEPTH.
- q, q_valid: direct from last-stage registers (no added latency).
- tap_q, tap_valid: combinational mux of stage/valid by tap_sel; tap_sel >= DEPTH (non-power-of-two DEPTH) returns tap_q=0, tap_valid=0.
- DEPTH=1: single stage; tap_sel ignored (always stage 0); primed == q_valid.
- No X propagation on outputs after first reset; d/d_valid don't-care when en=0.

Decomposition:
- Shared package (energy-detection common): clog2 constant function; default WIDTH constant for sample width.
- Sub-module ffd_en_vec: one stage, WIDTH+1 bits (data+valid), inputs clk, rst, clr, en, d; sync reset/clr to 0, load on en. ffd_en_pipe instantiates DEPTH of these in a generate loop plus counter and tap mux.

Test Plan:
- Reset: DEPTH=4, drive d=16'hFFFF, d_valid=1, en=1 for 6 cycles, assert rst 1 cycle -> next cycle q=0, q_valid=0, fill_cnt=0, primed=0.
- Latency/fill: en=1, d=1,2,3,4,5 with d_valid=1 on consecutive edges -> q=1 after 4th edge, primed rises same cycle fill_cnt=4; q=2 after 5th edge, fill_cnt stays 4.
- Enable hold: after loading 1..4, en=0 for 3 cycles with d=9 -> q, tap_q, fill_cnt unchanged; resume en=1 d=5 -> q=2.
- Invalid bubbles: pattern d_valid=1,0,1,0 (d=10,11,12,13) -> fill_cnt=2, primed=0, q=10 q_valid=1; one more en with d_valid=0 -> q=11 q_valid=0, fill_cnt=1.
- Tap: after loading 1..4 (stage0=4), tap_sel=0 -> tap_q=4; tap_sel=3 -> tap_q=1; DEPTH=3 build, tap_sel=3 -> tap_q=0, tap_valid=0.
- Flush vs enable: primed pipeline, clr=1 and en=1 with d=7 same edge -> all stages 0, fill_cnt=0; rst and clr together -> same result; DEPTH=1 build: d=5 en=1 -> q=5, primed=1 next cycle.
